// File: rtl/stack_controller.sv
`default_nettype none
// ============================================================================
// Module   : stack_controller
// Purpose  : Shares one CPU hardware stack between two requesters (core = 0,
//            interrupt unit = 1). It uses round-robin arbitration and owns the
//            downward-growing stack pointer and the occupancy count. It also
//            sequences single-port data-memory strobes for PUSH and POP.
//            Overflow and underflow requests get an error response and cause
//            no memory access.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            reqN_valid/pop/wdata - request from requester N (pop=1 => POP)
//            reqN_ready           - request N accepted this cycle (comb.)
//            rsp_valid/id/error/rdata - one-cycle completion pulse
//            mem_addr/we/re/wdata, mem_rdata - single-port stack memory
//                                   (read data valid the cycle after mem_re)
//            SP, depth            - stack pointer and occupied entries
//            stack_empty/full     - decoded from depth
//            stack_overflow       - sticky error flag, cleared by rst only
// Revision : 1.0 - initial release
// ============================================================================
module stack_controller #(
  parameter int unsigned DATA_W   = 16,
  parameter logic [9:0]  SP_BASE  = 10'd1023,
  parameter logic [9:0]  SP_LIMIT = 10'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_pop,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_pop,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic              rsp_error,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [9:0]        mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [9:0]        SP,
  output logic [10:0]       depth,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_overflow
);

  localparam logic [10:0] CAPACITY = {1'b0, SP_BASE} - {1'b0, SP_LIMIT} + 11'd1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    RWAIT = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [9:0]          sp_q, sp_d;
  logic [10:0]         depth_q, depth_d;
  logic                last_grant_q, last_grant_d;
  logic                id_q, id_d;
  logic                overflow_q, overflow_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic                rsp_error_q, rsp_error_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic [9:0]          mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                grant;
  logic                accept;
  logic                acc_pop;
  logic [DATA_W-1:0]   acc_wdata;
  logic                empty;
  logic                full;

  assign empty = (depth_q == 11'd0);
  assign full  = (depth_q == CAPACITY);

  // Round-robin: a contested cycle goes to whoever did not win last time.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = !rst && (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = !rst && (state_q == IDLE) && req1_valid &&  grant;
  assign accept     = req0_ready | req1_ready;
  assign acc_pop    = grant ? req1_pop   : req0_pop;
  assign acc_wdata  = grant ? req1_wdata : req0_wdata;

  // All outputs are registered. Each *_d holds the value for the state
  // being entered, so strobes and responses line up with that state's cycle.
  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    depth_d      = depth_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    overflow_d   = overflow_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = 1'b0;
    rsp_error_d  = 1'b0;
    rsp_rdata_d  = '0;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    mem_wdata_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          last_grant_d = grant;
          id_d         = grant;
          if (acc_pop ? empty : full) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant;
            rsp_error_d = 1'b1;
            overflow_d  = 1'b1;
          end else if (acc_pop) begin
            state_d  = READ;
            mem_re_d = 1'b1;
          end else begin
            state_d     = WRITE;
            mem_we_d    = 1'b1;
            mem_wdata_d = acc_wdata;
          end
        end
      end
      WRITE: begin
        sp_d        = sp_q - 10'd1;
        depth_d     = depth_q + 11'd1;
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
      end
      READ: begin
        sp_d    = sp_q + 10'd1;
        depth_d = depth_q - 11'd1;
        state_d = RWAIT;
      end
      RWAIT: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_rdata_d = mem_rdata;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A pop reads one above the current SP. Otherwise the address follows SP.
    mem_addr_d = mem_re_d ? (sp_q + 10'd1) : sp_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sp_q         <= SP_BASE;
      depth_q      <= 11'd0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      overflow_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= SP_BASE;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      depth_q      <= depth_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      overflow_q   <= overflow_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_error_q  <= rsp_error_d;
      rsp_rdata_q  <= rsp_rdata_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = rsp_id_q;
  assign rsp_error      = rsp_error_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign mem_we         = mem_we_q;
  assign mem_re         = mem_re_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign SP             = sp_q;
  assign depth          = depth_q;
  assign stack_empty    = empty;
  assign stack_full     = full;
  assign stack_overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_controller
// Purpose  : Randomized bench for stack_controller. A 4-entry stack is used
//            (SP_LIMIT = 1020) so that full and empty are reached often.
//            A queue-based model predicts the handshake, the strobes, the
//            responses and the pointer state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_controller;

  localparam int DW   = 16;
  localparam int BASE = 1023;
  localparam int CAP  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_pop, req0_ready;
  logic          req1_valid, req1_pop, req1_ready;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          rsp_valid, rsp_id, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic [9:0]    mem_addr;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [9:0]    SP;
  logic [10:0]   depth;
  logic          stack_empty, stack_full, stack_overflow;

  always #5 clk = ~clk;

  stack_controller #(
    .DATA_W  (DW),
    .SP_BASE (10'd1023),
    .SP_LIMIT(10'd1020)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_pop      (req0_pop),
    .req0_wdata    (req0_wdata),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_pop      (req1_pop),
    .req1_wdata    (req1_wdata),
    .req1_ready    (req1_ready),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_error     (rsp_error),
    .rsp_rdata     (rsp_rdata),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .SP            (SP),
    .depth         (depth),
    .stack_empty   (stack_empty),
    .stack_full    (stack_full),
    .stack_overflow(stack_overflow)
  );

  // Single-port memory: the read data appears the cycle after mem_re.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int            m_depth;
  logic [DW-1:0] m_stack[$];
  int            m_last;
  bit            m_sticky;
  bit            act;      // an operation is in flight
  int            t;        // cycles since its accept edge
  int            lat;      // cycle at which its response is due
  bit            o_pop, o_err;
  int            o_id;
  logic [DW-1:0] o_data;   // push data, or expected pop data
  bit            acc;
  int            a_id;
  bit            a_pop;
  logic [DW-1:0] a_wd;
  bit            rst_prev;

  // Requester-side holding registers
  bit            v[2];
  bit            p[2];
  logic [DW-1:0] w[2];

  task automatic model_reset();
    m_depth  = 0;
    m_stack.delete();
    m_last   = 1;
    m_sticky = 0;
    act      = 0;
    acc      = 0;
    t        = 0;
  endtask

  initial begin
    bit e_on, rv, idle, e_r0, e_r1;
    int g;
    rst = 1'b1;
    req0_valid = 0; req0_pop = 0; req0_wdata = '0;
    req1_valid = 0; req1_pop = 0; req1_wdata = '0;
    v[0] = 0; v[1] = 0; p[0] = 0; p[1] = 0; w[0] = '0; w[1] = '0;
    model_reset();
    rst_prev = 1;

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      // Advance the model across the edge that just happened.
      if (rst_prev) begin
        model_reset();
      end else begin
        if (act) t++;
        if (acc) begin
          act   = 1;
          t     = 1;
          o_id  = a_id;
          o_pop = a_pop;
          o_err = a_pop ? (m_depth == 0) : (m_depth == CAP);
          lat   = o_err ? 1 : (o_pop ? 3 : 2);
          o_data = a_wd;
          if (a_pop) begin
            o_data = '0;
            if (!o_err) o_data = m_stack[$];
          end
        end
        if (act && t == 2 && !o_err) begin
          if (o_pop) begin
            void'(m_stack.pop_back());
            m_depth--;
          end else begin
            m_stack.push_back(o_data);
            m_depth++;
          end
        end
        if (act && o_err && t == 1) m_sticky = 1;
        if (act && t > lat) act = 0;
      end
      acc = 0;

      // Registered outputs
      e_on = act && t == 1 && !o_err;
      check_eq("mem_we", mem_we, e_on && !o_pop);
      check_eq("mem_re", mem_re, e_on && o_pop);
      check_eq("mem_addr", mem_addr, (e_on && o_pop) ? BASE - m_depth + 1 : BASE - m_depth);
      check_eq("mem_wdata", mem_wdata, (e_on && !o_pop) ? o_data : 0);
      rv = act && t == lat;
      check_eq("rsp_valid", rsp_valid, rv);
      if (rv) begin
        check_eq("rsp_id", rsp_id, o_id);
        check_eq("rsp_error", rsp_error, o_err);
        check_eq("rsp_rdata", rsp_rdata, (o_pop && !o_err) ? o_data : 0);
      end
      check_eq("SP", SP, BASE - m_depth);
      check_eq("depth", depth, m_depth);
      check_eq("stack_empty", stack_empty, m_depth == 0);
      check_eq("stack_full", stack_full, m_depth == CAP);
      check_eq("stack_overflow", stack_overflow, m_sticky);

      // New stimulus for this cycle
      rst = 1'b0;
      if (c < 2) rst = 1'b1;
      else if (act && !o_err && !o_pop && t == 1 && $urandom_range(3) == 0) rst = 1'b1;

      if (c == 2) begin
        v[0] = 1; p[0] = 0; w[0] = 16'h1234;
      end else if (c > 2) begin
        for (int n = 0; n < 2; n++) begin
          if (!v[n] && ((c >= 1500 && c < 1800) || $urandom_range(1) == 1)) begin
            v[n] = 1;
            p[n] = (c >= 1500 && c < 1800) ? 1'b0 : 1'($urandom_range(1));
            w[n] = DW'($urandom);
          end
        end
      end
      req0_valid = v[0]; req0_pop = p[0]; req0_wdata = w[0];
      req1_valid = v[1]; req1_pop = p[1]; req1_wdata = w[1];
      #1;

      idle = !rst && !act;
      if (v[0] && v[1]) g = (m_last == 1) ? 0 : 1;
      else              g = v[1] ? 1 : 0;
      e_r0 = idle && v[0] && (g == 0);
      e_r1 = idle && v[1] && (g == 1);
      check_eq("req0_ready", req0_ready, e_r0);
      check_eq("req1_ready", req1_ready, e_r1);
      if (e_r0 || e_r1) begin
        acc    = 1;
        a_id   = g;
        a_pop  = p[g];
        a_wd   = w[g];
        m_last = g;
        v[g]   = 0;
      end
      rst_prev = rst;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
